// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl -- control block for a 10 ms resolution stopwatch.
//
// Conditions two raw pushbuttons, runs the IDLE/RUN/PAUSE/LAP state machine
// and produces the 10 ms count pulse that drives an external time-counter
// datapath.
//
// Configuration macro:
//   STOPWATCH_LAP_EN  defined   : display key enters/leaves LAP from RUN/LAP.
//                     undefined : display key is ignored in RUN, LAP is
//                                 unreachable, disp_hold/led[2] stay 0.
//
// Parameters:
//   TICK_DIV    clock cycles per 10 ms count tick
//   DEB_CYCLES  consecutive stable cycles needed to accept a key level change
//
// Ports:
//   CLOCK_50          in   sole clock, rising edge
//   key_reset         in   asynchronous active-low reset
//   key_start_pause   in   raw active-low pushbutton (asynchronous)
//   key_display_stop  in   raw active-low pushbutton (asynchronous)
//   count_en          out  one-cycle pulse, datapath advances 10 ms
//   count_clr         out  one-cycle pulse, datapath clears counters/display
//   disp_hold         out  level, datapath freezes display while high
//   state             out  IDLE=0, RUN=1, PAUSE=2, LAP=3
//   led               out  [0] running, [1] paused, [2] display held,
//                          [3] toggles on every count_en
// -----------------------------------------------------------------------------

// Synchronizer + debouncer + press detector for one active-low key.
module stopwatch_debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic press
);
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             deb_q;
   logic             press_q;
   logic [DEB_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         deb_q   <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q != deb_q) begin
            // cnt_q holds how many earlier cycles already differed, so the
            // level is accepted on the DEB_CYCLES-th consecutive differing cycle.
            if (cnt_q == DEB_LAST) begin
               deb_q   <= sync2_q;
               cnt_q   <= '0;
               press_q <= ~sync2_q;   // only the 1->0 (press) edge is reported
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;              // any bounce back restarts the count
         end
      end
   end

   assign press = press_q;
endmodule

module stopwatch_ctrl #(
   parameter int TICK_DIV   = 500000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       CLOCK_50,
   input  logic       key_reset,
   input  logic       key_start_pause,
   input  logic       key_display_stop,
   output logic       count_en,
   output logic       count_clr,
   output logic       disp_hold,
   output logic [1:0] state,
   output logic [3:0] led
);
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_LAP   = 2'd3
   } state_t;

   // key index 0 = start/pause, 1 = display/stop
   logic [1:0] key_raw;
   logic [1:0] press;

   assign key_raw = {key_display_stop, key_start_pause};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_key
         stopwatch_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
         ) u_deb (
            .clk     (CLOCK_50),
            .rst_n   (key_reset),
            .key_raw (key_raw[gi]),
            .press   (press[gi])
         );
      end
   endgenerate

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             count_en_q, count_en_d;
   logic             count_clr_q, count_clr_d;
   logic             disp_hold_q, disp_hold_d;
   logic [3:0]       led_q, led_d;
   logic             running;
   logic             start_ev;
   logic             disp_ev;

   // Start wins when both presses land in the same cycle.
   assign start_ev = press[0];
   assign disp_ev  = press[1] & ~press[0];
   assign running  = (state_q == S_RUN) || (state_q == S_LAP);

   always_comb begin
      state_d     = state_q;
      count_clr_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ev) state_d = S_RUN;
         end
         S_RUN: begin
            if (start_ev) state_d = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
            else if (disp_ev) state_d = S_LAP;
`endif
         end
         S_PAUSE: begin
            if (start_ev) begin
               state_d = S_RUN;
            end else if (disp_ev) begin
               state_d     = S_IDLE;
               count_clr_d = 1'b1;
            end
         end
`ifdef STOPWATCH_LAP_EN
         S_LAP: begin
            if (start_ev)     state_d = S_PAUSE;
            else if (disp_ev) state_d = S_RUN;
         end
`endif
         default: state_d = state_q;
      endcase
   end

   // Divider advances on the current state, so the first tick after entering
   // RUN lands TICK_DIV cycles after state shows RUN; PAUSE keeps the partial tick.
   always_comb begin
      div_d      = div_q;
      count_en_d = 1'b0;
      if (state_q == S_IDLE) begin
         div_d = '0;
      end else if (running) begin
         if (div_q == DIV_LAST) begin
            div_d      = '0;
            count_en_d = 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_comb begin
`ifdef STOPWATCH_LAP_EN
      disp_hold_d = (state_d == S_LAP);
`else
      disp_hold_d = 1'b0;
`endif
      // Status LEDs follow the next state so they change on the same edge as state.
      led_d = {led_q[3] ^ count_en_d,
               disp_hold_d,
               (state_d == S_PAUSE),
               (state_d == S_RUN) || (state_d == S_LAP)};
   end

   always_ff @(posedge CLOCK_50 or negedge key_reset) begin
      if (!key_reset) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         count_en_q  <= 1'b0;
         count_clr_q <= 1'b0;
         disp_hold_q <= 1'b0;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         count_en_q  <= count_en_d;
         count_clr_q <= count_clr_d;
         disp_hold_q <= disp_hold_d;
         led_q       <= led_d;
      end
   end

   assign state     = state_q;
   assign count_en  = count_en_q;
   assign count_clr = count_clr_q;
   assign disp_hold = disp_hold_q;
   assign led       = led_q;
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: TICK_DIV, 500000, CLOCK_50 cycles per 10 ms count tick.
REQ-002 Parameter: DEB_CYCLES, 1000000, consecutive stable cycles required to accept a key level change.
REQ-003 Port: CLOCK_50  in  1  sole clock; all state is on its rising edge.
REQ-004 Port: key_reset  in  1  asynchronous active-low reset.
REQ-005 Port: key_start_pause  in  1  raw active-low pushbutton, asynchronous to CLOCK_50.
REQ-006 Port: key_display_stop  in  1  raw active-low pushbutton, asynchronous to CLOCK_50.
REQ-007 Port: count_en  out  1  one-cycle pulse; the time-counter datapath advances 10 ms.
REQ-008 Port: count_clr  out  1  one-cycle pulse; the datapath clears its counters and display.
REQ-009 Port: disp_hold  out  1  level; the datapath freezes its display registers while high.
REQ-010 Port: state  out  2  current FSM state: IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-011 Port: led  out  4  status LEDs.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: the debounced level SHALL update only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 Press event: a one-cycle pulse on each debounced 1->0 transition; releases generate nothing.
REQ-015 FSM transitions from IDLE: start press -> RUN; display press ignored.
REQ-016 FSM transitions from RUN: start press -> PAUSE; display press -> LAP.
REQ-017 FSM transitions from PAUSE: start press -> RUN; display press -> IDLE, with count_clr high for exactly the transition cycle.
REQ-018 FSM transitions from LAP: start press -> PAUSE; display press -> RUN.
REQ-019 Simultaneous start and display presses in one cycle: start SHALL be taken and display discarded.
REQ-020 Tick divider counts 0..TICK_DIV-1 and wraps, incrementing only in RUN or LAP.
REQ-021 Tick divider holds its value in PAUSE, so a resumed run keeps the partial tick.
REQ-022 Tick divider is cleared to 0 in IDLE.
REQ-023 count_en SHALL be high for one cycle when the divider equals TICK_DIV-1 in RUN or LAP; first tick after IDLE->RUN arrives exactly TICK_DIV cycles after state shows RUN.
REQ-024 disp_hold SHALL be registered and high exactly while state==LAP.
REQ-025 led[0]=RUN or LAP; led[1]=PAUSE; led[2]=disp_hold; led[3] toggles on every count_en.
REQ-026 All outputs SHALL be registered and SHALL be glitch-free.

Reset
REQ-027 key_reset low SHALL immediately set: state=IDLE, divider=0, debounced levels=1, synchronizers=1, count_en=0, count_clr=0, disp_hold=0, led=0.
REQ-028 Reset asserted mid-RUN or mid-LAP SHALL abort with no count_en or count_clr pulse; the datapath resets from key_reset directly.
REQ-029 The first press event after reset release SHALL require a full DEB_CYCLES-stable low.

Configuration
REQ-030 Macro STOPWATCH_LAP_EN defined: LAP state and display-press transitions out of RUN and LAP behave as in REQ-016 and REQ-018.
REQ-031 STOPWATCH_LAP_EN undefined: a display press in RUN SHALL be ignored, LAP is unreachable, disp_hold and led[2] are constant 0, and the PAUSE->IDLE clear is unchanged.

Verification (TICK_DIV=4, DEB_CYCLES=3)
REQ-032 Reset release, key_start_pause held low 10 cycles -> state IDLE->RUN once; count_en pulses every 4 cycles thereafter.
REQ-033 key_start_pause toggling every cycle for 20 cycles -> no press event; state unchanged.
REQ-034 RUN, pause after divider=2, resume -> first count_en 1 cycle after state returns to RUN.
REQ-035 RUN, display press -> state=3, disp_hold=1, count_en continues; second display press -> state=1, disp_hold=0.
REQ-036 PAUSE, display press -> count_clr=1 for one cycle, state=0, divider=0; both keys pressed together from RUN -> state=2 only.
REQ-037 key_reset pulsed low during LAP -> all outputs 0 asynchronously; with STOPWATCH_LAP_EN undefined, display press in RUN leaves state=1.
